// File: rtl/jedro_1_prog_checker.sv
// rtl/jedro_1_prog_checker.sv - end-of-program regfile checker for jedro_1 benches
// Optional write counter and zero-write fail rule: JEDRO_1_PROG_CHECKER_WCNT_EN
module jedro_1_prog_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_CYCLES     = 32,
  parameter int DRAIN_CYCLES   = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      illegal_instr_i,
  input  logic                      rf_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] rf_waddr_i,
  input  logic [DATA_WIDTH-1:0]     rf_wdata_i,
  input  logic                      exp_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] exp_addr_i,
  input  logic [DATA_WIDTH-1:0]     exp_data_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic                      timeout_o,
  output logic [REG_ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0]     fail_data_o,
  output logic [CNT_WIDTH-1:0]      cycle_cnt_o
`ifdef JEDRO_1_PROG_CHECKER_WCNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      wr_cnt_o
`endif
);

  localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
  localparam int DRAIN_W  = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_CYCLES);

  logic [2:0]                state;
  logic [CNT_WIDTH-1:0]      cycle_cnt;
  logic [DRAIN_W-1:0]        drain_cnt;
  logic [REG_ADDR_WIDTH-1:0] scan_idx;
  logic                      timeout;
  logic                      pass;
  logic [REG_ADDR_WIDTH-1:0] fail_addr;
  logic [DATA_WIDTH-1:0]     fail_data;

  logic [NUM_REGS-1:0]       exp_valid;
  logic [DATA_WIDTH-1:0]     exp_data [NUM_REGS];
  logic [DATA_WIDTH-1:0]     shadow   [NUM_REGS];

  logic busy;
  logic idle_or_done;
  logic start_ok;
  logic shadow_wr;
  logic entry_bad;
  logic run_end;

  assign busy         = (state == S_RUN) || (state == S_DRAIN) || (state == S_CHECK);
  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign start_ok     = start_i && idle_or_done;
  // x0 is never written, so shadow[0] stays at its cleared value of zero
  assign shadow_wr    = rf_we_i && ((state == S_RUN) || (state == S_DRAIN)) &&
                        (rf_waddr_i != '0);
  assign entry_bad    = exp_valid[scan_idx] && (shadow[scan_idx] != exp_data[scan_idx]);
  assign run_end      = illegal_instr_i || (cycle_cnt == MAX_CNT - 1'b1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exp_valid <= '0;
    end else if (exp_we_i && idle_or_done) begin
      exp_valid[exp_addr_i] <= 1'b1;
    end
  end

  // Entry data is only meaningful under its valid bit, so it needs no reset
  always_ff @(posedge clk_i) begin
    if (exp_we_i && idle_or_done) begin
      exp_data[exp_addr_i] <= exp_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
      end
    end else if (shadow_wr) begin
      shadow[rf_waddr_i] <= rf_wdata_i;
    end
  end

`ifdef JEDRO_1_PROG_CHECKER_WCNT_EN
  logic [CNT_WIDTH-1:0] wr_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) begin
      wr_cnt <= '0;
    end else if (shadow_wr && (wr_cnt != '1)) begin
      wr_cnt <= wr_cnt + 1'b1;
    end
  end

  assign wr_cnt_o = wr_cnt;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      cycle_cnt <= '0;
      drain_cnt <= '0;
      scan_idx  <= '0;
      timeout   <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state     <= S_RUN;
            cycle_cnt <= '0;
            scan_idx  <= '0;
            timeout   <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
          end
        end
        S_RUN: begin
          if (cycle_cnt != MAX_CNT) begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
          // illegal wins over budget expiry when both land in the same cycle
          if (run_end) begin
            timeout  <= !illegal_instr_i;
            scan_idx <= '0;
            if (DRAIN_CYCLES == 0) begin
              state <= S_CHECK;
            end else begin
              state     <= S_DRAIN;
              drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_W'(1)) begin
            state <= S_CHECK;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        S_CHECK: begin
          if (entry_bad) begin
            fail_addr <= scan_idx;
            fail_data <= shadow[scan_idx];
            pass      <= 1'b0;
            state     <= S_DONE;
          end else if (scan_idx == '1) begin
`ifdef JEDRO_1_PROG_CHECKER_WCNT_EN
            pass  <= !timeout && (wr_cnt != '0);
`else
            pass  <= !timeout;
`endif
            state <= S_DONE;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy;
  assign done_o      = (state == S_DONE);
  assign pass_o      = pass;
  assign timeout_o   = timeout;
  assign fail_addr_o = fail_addr;
  assign fail_data_o = fail_data;
  assign cycle_cnt_o = cycle_cnt;

endmodule

// File: tb/tb_jedro_1_prog_checker.sv
// tb/tb_jedro_1_prog_checker.sv - self-checking bench for jedro_1_prog_checker
module tb_jedro_1_prog_checker;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int MAXC = 32;
  localparam int DRN  = 3;
  localparam int CW   = 16;
  localparam int NREG = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0, start = 1'b0, illegal = 1'b0, rf_we = 1'b0, exp_we = 1'b0;
  logic [AW-1:0] rf_waddr = '0, exp_addr = '0;
  logic [DW-1:0] rf_wdata = '0, exp_data = '0;
  logic          busy, done, pass, timeout;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [CW-1:0] cycle_cnt;
`ifdef JEDRO_1_PROG_CHECKER_WCNT_EN
  logic [CW-1:0] wr_cnt;
`endif

  jedro_1_prog_checker #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .MAX_CYCLES(MAXC),
    .DRAIN_CYCLES(DRN), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .illegal_instr_i(illegal),
    .rf_we_i(rf_we), .rf_waddr_i(rf_waddr), .rf_wdata_i(rf_wdata),
    .exp_we_i(exp_we), .exp_addr_i(exp_addr), .exp_data_i(exp_data),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(timeout),
    .fail_addr_o(fail_addr), .fail_data_o(fail_data), .cycle_cnt_o(cycle_cnt)
`ifdef JEDRO_1_PROG_CHECKER_WCNT_EN
    , .wr_cnt_o(wr_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Program: per RUN cycle (1-based) a write and noise strobes, per DRAIN cycle a write
  logic          p_we [0:63];
  logic [AW-1:0] p_addr [0:63];
  logic [DW-1:0] p_data [0:63];
  logic          p_snoise [0:63];
  logic          p_enoise [0:63];
  logic          d_we [1:DRN];
  logic [AW-1:0] d_addr [1:DRN];
  logic [DW-1:0] d_data [1:DRN];
  int            p_ill;

  logic          m_ev [NREG];
  logic [DW-1:0] m_ed [NREG];
  logic [DW-1:0] m_sh [NREG];
  logic          m_pass, m_timeout;
  int            m_cnt, m_wr;
  logic [AW-1:0] m_faddr;
  logic [DW-1:0] m_fdata;

  typedef struct {
    int          ill;
    logic [AW-1:0] ea0;
    logic [DW-1:0] ed0;
    logic          ev1;
    logic [AW-1:0] ea1;
    logic [DW-1:0] ed1;
    logic          x_pass;
    logic          x_to;
    int            x_cnt;
    logic [AW-1:0] x_fa;
    logic [DW-1:0] x_fd;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int k = 0; k < 64; k++) begin
      p_we[k] = 1'b0; p_addr[k] = '0; p_data[k] = '0;
      p_snoise[k] = 1'b0; p_enoise[k] = 1'b0;
    end
    for (int d = 1; d <= DRN; d++) begin
      d_we[d] = 1'b0; d_addr[d] = '0; d_data[d] = '0;
    end
    p_ill = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_pass"}, pass, 1'b0);
    chk({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_fail_addr"}, fail_addr, '0);
    chk({tag, "_fail_data"}, fail_data, '0);
    chk({tag, "_cycle_cnt"}, cycle_cnt, '0);
`ifdef JEDRO_1_PROG_CHECKER_WCNT_EN
    chk({tag, "_wr_cnt"}, wr_cnt, '0);
`endif
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; start = 1'b0; illegal = 1'b0; rf_we = 1'b0; exp_we = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      m_ev[i] = 1'b0; m_ed[i] = '0;
    end
    check_idle_outputs(tag);
  endtask

  task automatic load_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_we = 1'b1; exp_addr = a; exp_data = d;
    tick();
    exp_we = 1'b0;
    m_ev[a] = 1'b1;
    m_ed[a] = d;
  endtask

  // Reference: the program ends at the illegal cycle or at the budget, then DRN drain writes land
  task automatic model_run();
    int  e;
    logic found;
    for (int i = 0; i < NREG; i++) m_sh[i] = '0;
    m_timeout = !(p_ill >= 1 && p_ill <= MAXC);
    e = m_timeout ? MAXC : p_ill;
    m_wr = 0;
    for (int k = 1; k <= e; k++)
      if (p_we[k] && p_addr[k] != 0) begin m_sh[p_addr[k]] = p_data[k]; m_wr++; end
    for (int d = 1; d <= DRN; d++)
      if (d_we[d] && d_addr[d] != 0) begin m_sh[d_addr[d]] = d_data[d]; m_wr++; end
    m_cnt = e;
    m_faddr = '0; m_fdata = '0; found = 1'b0;
    for (int i = 0; i < NREG; i++)
      if (!found && m_ev[i] && m_sh[i] != m_ed[i]) begin
        found = 1'b1; m_faddr = AW'(i); m_fdata = m_sh[i];
      end
    m_pass = !found && !m_timeout;
`ifdef JEDRO_1_PROG_CHECKER_WCNT_EN
    if (m_wr == 0) m_pass = 1'b0;
`endif
  endtask

  task automatic run_prog();
    int e;
    int t;
    e = (p_ill >= 1 && p_ill <= MAXC) ? p_ill : MAXC;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= e; k++) begin
      illegal = (k == p_ill);
      rf_we = p_we[k]; rf_waddr = p_addr[k]; rf_wdata = p_data[k];
      start = p_snoise[k];
      exp_we = p_enoise[k]; exp_addr = AW'($urandom); exp_data = $urandom;
      tick();
      chk("busy_in_run", busy, 1'b1);
    end
    start = 1'b0; exp_we = 1'b0;
    for (int d = 1; d <= DRN; d++) begin
      illegal = 1'($urandom);
      rf_we = d_we[d]; rf_waddr = d_addr[d]; rf_wdata = d_data[d];
      tick();
    end
    illegal = 1'b0;
    t = 0;
    while (!done && t < NREG) begin
      rf_we = (t < 3); rf_waddr = AW'($urandom_range(1, NREG - 1)); rf_wdata = $urandom;
      tick();
      t++;
    end
    rf_we = 1'b0;
    chk("done_within_scan", done, 1'b1);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_pass"}, pass, m_pass);
    chk({tag, "_timeout"}, timeout, m_timeout);
    chk({tag, "_cycle_cnt"}, cycle_cnt, CW'(m_cnt));
    chk({tag, "_fail_addr"}, fail_addr, m_faddr);
    chk({tag, "_fail_data"}, fail_data, m_fdata);
`ifdef JEDRO_1_PROG_CHECKER_WCNT_EN
    chk({tag, "_wr_cnt"}, wr_cnt, CW'(m_wr));
`endif
  endtask

  task automatic fixed_prog();
    clear_prog();
    p_we[1] = 1'b1; p_addr[1] = 5'd1; p_data[1] = 32'd1;
    p_we[2] = 1'b1; p_addr[2] = 5'd1; p_data[2] = 32'd3;
    p_we[3] = 1'b1; p_addr[3] = 5'd1; p_data[3] = 32'd6;
    p_we[4] = 1'b1; p_addr[4] = 5'd1; p_data[4] = 32'd10;
    p_we[5] = 1'b1; p_addr[5] = 5'd1; p_data[5] = 32'd15;
    p_we[6] = 1'b1; p_addr[6] = 5'd3; p_data[6] = 32'h33;
    p_we[7] = 1'b1; p_addr[7] = 5'd7; p_data[7] = 32'h77;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            ill ea0    ed0      ev1   ea1    ed1      pass  to    cnt fa     fd
    vecs[0] = '{8,  5'd1, 32'd15,  1'b0, 5'd0, 32'd0,   1'b1, 1'b0, 8,  5'd0, 32'd0};
    vecs[1] = '{8,  5'd1, 32'd16,  1'b0, 5'd0, 32'd0,   1'b0, 1'b0, 8,  5'd1, 32'd15};
    vecs[2] = '{8,  5'd7, 32'h70,  1'b1, 5'd3, 32'h30,  1'b0, 1'b0, 8,  5'd3, 32'h33};
    vecs[3] = '{0,  5'd1, 32'd15,  1'b0, 5'd0, 32'd0,   1'b0, 1'b1, 32, 5'd0, 32'd0};
    vecs[4] = '{32, 5'd1, 32'd15,  1'b0, 5'd0, 32'd0,   1'b1, 1'b0, 32, 5'd0, 32'd0};
    vecs[5] = '{6,  5'd3, 32'h33,  1'b1, 5'd7, 32'h77,  1'b0, 1'b0, 6,  5'd7, 32'd0};
    vecs[6] = '{1,  5'd1, 32'd1,   1'b0, 5'd0, 32'd0,   1'b1, 1'b0, 1,  5'd0, 32'd0};
    vecs[7] = '{40, 5'd7, 32'h77,  1'b0, 5'd0, 32'd0,   1'b0, 1'b1, 32, 5'd0, 32'd0};

    tick();
    do_reset("reset");

    for (int v = 0; v < 8; v++) begin
      do_reset("vec_reset");
      fixed_prog();
      p_ill = vecs[v].ill;
      load_exp(vecs[v].ea0, vecs[v].ed0);
      if (vecs[v].ev1) load_exp(vecs[v].ea1, vecs[v].ed1);
      run_prog();
      chk($sformatf("vec%0d_pass", v), pass, vecs[v].x_pass);
      chk($sformatf("vec%0d_timeout", v), timeout, vecs[v].x_to);
      chk($sformatf("vec%0d_cycle_cnt", v), cycle_cnt, CW'(vecs[v].x_cnt));
      chk($sformatf("vec%0d_fail_addr", v), fail_addr, vecs[v].x_fa);
      chk($sformatf("vec%0d_fail_data", v), fail_data, vecs[v].x_fd);
    end

    // x0 write dropped, write inside DRAIN kept
    do_reset("x0_reset");
    clear_prog();
    p_we[2] = 1'b1; p_addr[2] = 5'd0; p_data[2] = 32'hDEAD;
    p_ill = 4;
    d_we[1] = 1'b1; d_addr[1] = 5'd2; d_data[1] = 32'd5;
    load_exp(5'd0, 32'd0);
    load_exp(5'd2, 32'd5);
    model_run();
    run_prog();
    check_model("x0_drain");
    chk("x0_drain_pass_const", pass, 1'b1);

    // restart from DONE: table kept, shadow cleared
    model_run();
    run_prog();
    check_model("restart_same");
    d_we[1] = 1'b0;
    model_run();
    run_prog();
    check_model("restart_cleared");
    chk("restart_fail_addr_const", fail_addr, 5'd2);
    chk("restart_fail_data_const", fail_data, 32'd0);

    // reset during DRAIN, then a clean run with an empty table
    clear_prog();
    load_exp(5'd4, 32'h1234);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      illegal = (k == 3); tick();
    end
    illegal = 1'b0;
    tick();
    chk("drain_before_reset_busy", busy, 1'b1);
    do_reset("reset_in_drain");
    clear_prog();
    p_ill = 2;
    model_run();
    run_prog();
    check_model("after_reset");
`ifdef JEDRO_1_PROG_CHECKER_WCNT_EN
    chk("after_reset_pass_const", pass, 1'b0);
`else
    chk("after_reset_pass_const", pass, 1'b1);
`endif

    // randomized programs against the reference, each replayed from DONE
    for (int r = 0; r < 25; r++) begin
      int nexp;
      logic [AW-1:0] a;
      do_reset("rnd_reset");
      clear_prog();
      p_ill = $urandom_range(1, 40);
      for (int k = 1; k <= 40; k++) begin
        p_we[k]     = ($urandom_range(0, 1) == 1);
        p_addr[k]   = AW'($urandom_range(0, 7));
        p_data[k]   = $urandom;
        p_snoise[k] = ($urandom_range(0, 15) == 0);
        p_enoise[k] = ($urandom_range(0, 7) == 0);
      end
      for (int d = 1; d <= DRN; d++) begin
        d_we[d] = ($urandom_range(0, 1) == 1);
        d_addr[d] = AW'($urandom_range(0, 7));
        d_data[d] = $urandom;
      end
      model_run();
      nexp = $urandom_range(0, 4);
      for (int j = 0; j < nexp; j++) begin
        a = AW'($urandom_range(0, 9));
        if ($urandom_range(0, 3) != 0) load_exp(a, m_sh[a]);
        else load_exp(a, $urandom);
      end
      model_run();
      run_prog();
      check_model("rnd");
      tick(); tick();
      chk("rnd_hold_pass", pass, m_pass);
      chk("rnd_hold_done", done, 1'b1);
      run_prog();
      check_model("rnd_replay");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
